// File: rtl/pipe_trace_buffer_if.sv
// Capture, control and replay signals of the pipeline trace buffer.
interface pipe_trace_buffer_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEPTH      = 16
);
    localparam int unsigned REC_W = NUM_CH * DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             In_Valid;
    logic [REC_W-1:0] In_Data;
    logic             In_Trigger;
    logic             Arm;
    logic             Out_Valid;
    logic             Out_Ready;
    logic [REC_W-1:0] Out_Data;
    logic             Out_Last;
    logic [1:0]       Out_State;
    logic [CNT_W-1:0] Out_Count;

    modport master (
        output In_Valid, In_Data, In_Trigger, Arm, Out_Ready,
        input  Out_Valid, Out_Data, Out_Last, Out_State, Out_Count
    );

    modport slave (
        input  In_Valid, In_Data, In_Trigger, Arm, Out_Ready,
        output Out_Valid, Out_Data, Out_Last, Out_State, Out_Count
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace capture around a trigger event, replayed oldest-first
// over a valid/ready port.
module pipe_trace_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned POST_TRIG  = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    pipe_trace_buffer_if.slave bus
);
    localparam int unsigned REC_W = NUM_CH * DATA_WIDTH;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_READ = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0] post_cnt, post_cnt_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [CNT_W-1:0] remaining, remaining_nxt;
    logic             we;
    logic [REC_W-1:0] mem [DEPTH];

    // State and pointer registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            post_cnt  <= '0;
            count     <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            post_cnt  <= post_cnt_nxt;
            count     <= count_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state and pointer update
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        post_cnt_nxt  = post_cnt;
        count_nxt     = count;
        remaining_nxt = remaining;
        we            = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.Arm) begin
                    state_nxt  = S_PRE;
                    wr_ptr_nxt = '0;
                    count_nxt  = '0;
                end
            end
            S_PRE, S_POST: begin
                if (bus.Arm) begin
                    // Restart drops whatever record arrives alongside Arm
                    state_nxt  = S_PRE;
                    wr_ptr_nxt = '0;
                    count_nxt  = '0;
                end else if (bus.In_Valid) begin
                    we         = 1'b1;
                    wr_ptr_nxt = wr_ptr + PTR_W'(1);
                    if (count != CNT_W'(DEPTH)) begin
                        count_nxt = count + CNT_W'(1);
                    end
                    if (state == S_PRE) begin
                        if (bus.In_Trigger) begin
                            if (POST_TRIG == 0) begin
                                state_nxt = S_READ;
                            end else begin
                                state_nxt    = S_POST;
                                post_cnt_nxt = PTR_W'(POST_TRIG);
                            end
                        end
                    end else begin
                        post_cnt_nxt = post_cnt - PTR_W'(1);
                        if (post_cnt == PTR_W'(1)) begin
                            state_nxt = S_READ;
                        end
                    end
                end
            end
            S_READ: begin
                if (bus.Out_Ready) begin
                    rd_ptr_nxt    = rd_ptr + PTR_W'(1);
                    remaining_nxt = remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Oldest record sits Count entries behind the write pointer; a full
        // buffer truncates Count to 0, pointing at wr_ptr itself.
        if (state != S_READ && state_nxt == S_READ) begin
            rd_ptr_nxt    = wr_ptr_nxt - PTR_W'(count_nxt);
            remaining_nxt = count_nxt;
        end
    end

    // Record storage, intentionally not reset
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[wr_ptr] <= bus.In_Data;
        end
    end

    assign bus.Out_Valid = (state == S_READ);
    assign bus.Out_Data  = (state == S_READ) ? mem[rd_ptr] : '0;
    assign bus.Out_Last  = (state == S_READ) && (remaining == CNT_W'(1));
    assign bus.Out_State = state;
    assign bus.Out_Count = count;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: capture scenarios with a
// replay scoreboard.
module tb_pipe_trace_buffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PT    = 3;
    localparam int unsigned RW    = NCH * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_trace_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH)) bus ();

    pipe_trace_buffer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .POST_TRIG(PT)
    ) dut (
        .Clk(clk),
        .Rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int n_push;
        int trig_k;
        int first;
        int last;
        int cnt;
        bit stall;
    } vec_t;

    vec_t            tbl [5];
    int              checks = 0;
    int              errors = 0;
    logic [RW-1:0]   exp_q [$];

    function automatic logic [RW-1:0] rec(input int k);
        return {32'(k + 100), 32'(k)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.In_Valid   = 1'b0;
        bus.In_Trigger = 1'b0;
        bus.Arm        = 1'b0;
        bus.In_Data    = '0;
    endtask

    task automatic arm();
        bus.Arm = 1'b1;
        tick();
        bus.Arm = 1'b0;
    endtask

    task automatic push(input int k, input bit trig);
        bus.In_Valid   = 1'b1;
        bus.In_Data    = rec(k);
        bus.In_Trigger = trig;
        tick();
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"}, 64'(bus.Out_Valid), 64'd0);
        check({tag, " state"}, 64'(bus.Out_State), 64'd0);
        check({tag, " count"}, 64'(bus.Out_Count), 64'd0);
        check({tag, " data"},  64'(bus.Out_Data),  64'd0);
    endtask

    task automatic load_expected(input int first, input int last);
        for (int k = first; k <= last; k++) exp_q.push_back(rec(k));
    endtask

    // Pop one expected record per accepted handshake; stalled cycles must hold
    task automatic drain(input bit stall, input int exp_count);
        logic [RW-1:0] held;
        logic          held_last;
        logic [RW-1:0] e;
        bit            was_stalled;
        held        = '0;
        held_last   = 1'b0;
        was_stalled = 1'b0;
        check("replay count", 64'(bus.Out_Count), 64'(exp_count));
        for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
            bus.Out_Ready = stall ? (cyc % 2 == 1) : 1'b1;
            if (!bus.Out_Valid) begin
                check("valid during replay", 64'(bus.Out_Valid), 64'd1);
                break;
            end
            if (was_stalled) begin
                check("stall data hold", 64'(bus.Out_Data), 64'(held));
                check("stall last hold", 64'(bus.Out_Last), 64'(held_last));
            end
            if (bus.Out_Ready) begin
                e = exp_q.pop_front();
                check("replay data", 64'(bus.Out_Data), 64'(e));
                check("replay last", 64'(bus.Out_Last), 64'(exp_q.size() == 0));
                was_stalled = 1'b0;
            end else begin
                held        = bus.Out_Data;
                held_last   = bus.Out_Last;
                was_stalled = 1'b1;
            end
            tick();
        end
        bus.Out_Ready = 1'b0;
        check("records left unreplayed", 64'(exp_q.size()), 64'd0);
        check("valid after last", 64'(bus.Out_Valid), 64'd0);
        check("idle after last", 64'(bus.Out_State), 64'd0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int last_k;
        last_k = 0;
        arm();
        check("armed state", 64'(bus.Out_State), 64'd1);
        for (int k = 1; k <= v.n_push; k++) begin
            push(k, k == v.trig_k);
            last_k = k;
            if (bus.Out_State == 2'd3) break;
        end
        check("read entered", 64'(bus.Out_State), 64'd3);
        check("read entry record", 64'(last_k), 64'(v.last));
        load_expected(v.first, v.last);
        drain(v.stall, v.cnt);
    endtask

    initial begin
        tbl[0] = '{n_push: 20, trig_k: 10, first: 6, last: 13, cnt: 8, stall: 1'b0};
        tbl[1] = '{n_push: 6,  trig_k: 3,  first: 1, last: 6,  cnt: 6, stall: 1'b0};
        tbl[2] = '{n_push: 20, trig_k: 10, first: 6, last: 13, cnt: 8, stall: 1'b1};
        tbl[3] = '{n_push: 10, trig_k: 1,  first: 1, last: 4,  cnt: 4, stall: 1'b0};
        tbl[4] = '{n_push: 10, trig_k: 5,  first: 1, last: 8,  cnt: 8, stall: 1'b1};

        idle_inputs();
        bus.Out_Ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Records offered in IDLE are not captured
        push(50, 1'b1);
        check("idle ignores input state", 64'(bus.Out_State), 64'd0);
        check("idle ignores input count", 64'(bus.Out_Count), 64'd0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Trigger qualifiers that must be ignored, and Arm during replay
        arm();
        bus.In_Trigger = 1'b1;
        tick();
        idle_inputs();
        check("trigger without valid", 64'(bus.Out_State), 64'd1);
        push(1, 1'b0);
        push(2, 1'b1);
        check("post after trigger", 64'(bus.Out_State), 64'd2);
        push(3, 1'b1);
        check("second trigger ignored", 64'(bus.Out_State), 64'd2);
        push(4, 1'b0);
        push(5, 1'b0);
        check("post window closed", 64'(bus.Out_State), 64'd3);
        arm();
        push(6, 1'b1);
        check("arm in read ignored", 64'(bus.Out_State), 64'd3);
        load_expected(1, 5);
        drain(1'b0, 5);

        // Reset while in POST, then repeat the early-trigger capture
        arm();
        push(1, 1'b0);
        push(2, 1'b0);
        push(3, 1'b1);
        push(4, 1'b0);
        check("mid post state", 64'(bus.Out_State), 64'd2);
        rst = 1'b1;
        #2;
        check_reset_outputs("async reset");
        tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("after reset");
        run_vec(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
